// File: rtl/uart_pkg.sv
// UART RX shared types: parity modes, frame FSM states
// and the expected-parity helper.
package uart_pkg;

  localparam logic [1:0] PAR_EVEN  = 2'b00;
  localparam logic [1:0] PAR_ODD   = 2'b01;
  localparam logic [1:0] PAR_MARK  = 2'b10;
  localparam logic [1:0] PAR_SPACE = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } rx_state_t;

  function automatic logic par_expect(
    input logic [1:0] ptype,
    input logic       xor_data
  );
    logic e;
    e = 1'b0;
    unique case (ptype)
      PAR_EVEN:  e = xor_data;
      PAR_ODD:   e = ~xor_data;
      PAR_MARK:  e = 1'b1;
      PAR_SPACE: e = 1'b0;
      default:   e = 1'b0;
    endcase
    return e;
  endfunction

endpackage

// File: rtl/uart_sat_counter.sv
// Saturating event counter with synchronous clear;
// clear beats increment.
module uart_sat_counter #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 inc,
  input  logic                 clr,
  output logic [CNT_WIDTH-1:0] cnt
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + CNT_WIDTH'(1);
    end
  end

endmodule

// File: rtl/uart_rx_frame_check.sv
// UART RX frame assembler/checker: LSB-first data,
// parity and stop checks, held valid/ready output.
module uart_rx_frame_check
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int STOP_BITS  = 1,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cfg_par_en,
  input  logic [1:0]            cfg_par_type,
  input  logic                  start_stb,
  input  logic                  bit_stb,
  input  logic                  bit_val,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_par_err,
  output logic                  out_stop_err,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  overrun,
  output logic                  busy,
  input  logic                  clr_cnt,
  output logic [CNT_WIDTH-1:0]  par_err_cnt,
  output logic [CNT_WIDTH-1:0]  stop_err_cnt
);

  localparam int BW = $clog2(DATA_WIDTH + 1);

  rx_state_t state, state_nxt;

  logic [BW-1:0]         bit_cnt;
  logic [DATA_WIDTH-1:0] shreg;
  logic                  par_acc;
  logic                  par_en_q;
  logic [1:0]            par_type_q;
  logic                  par_err_q;
  logic                  stop_err_q;
  logic                  stop_idx;
  logic                  data_last;
  logic                  stop_last;
  logic                  done;
  logic                  fin_par_err;
  logic                  fin_stop_err;

  assign data_last = bit_stb && (bit_cnt == BW'(DATA_WIDTH - 1));
  assign stop_last = bit_stb && ((STOP_BITS == 1) || stop_idx);

  // Final flags include the stop bit being sampled this cycle.
  assign fin_stop_err = stop_err_q | ~bit_val;
  assign fin_par_err  = par_en_q & par_err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start_stb) state_nxt = DATA;
      DATA:    if (data_last)
                 state_nxt = par_en_q ? PARITY : STOP;
      PARITY:  if (bit_stb) state_nxt = STOP;
      STOP:    if (stop_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
    done = (state == STOP) && stop_last;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt    <= '0;
      shreg      <= '0;
      par_acc    <= 1'b0;
      par_en_q   <= 1'b0;
      par_type_q <= PAR_EVEN;
      par_err_q  <= 1'b0;
      stop_err_q <= 1'b0;
      stop_idx   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (start_stb) begin
          par_en_q   <= cfg_par_en;
          par_type_q <= cfg_par_type;
          bit_cnt    <= '0;
          par_acc    <= 1'b0;
          par_err_q  <= 1'b0;
          stop_err_q <= 1'b0;
          stop_idx   <= 1'b0;
        end
        DATA: if (bit_stb) begin
          shreg   <= {bit_val, shreg[DATA_WIDTH-1:1]};
          par_acc <= par_acc ^ bit_val;
          bit_cnt <= bit_cnt + BW'(1);
        end
        PARITY: if (bit_stb) begin
          par_err_q <= par_expect(par_type_q, par_acc)
                       ^ bit_val;
        end
        STOP: if (bit_stb) begin
          stop_err_q <= fin_stop_err;
          stop_idx   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // A held, unaccepted frame wins; the new one is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid    <= 1'b0;
      out_data     <= '0;
      out_par_err  <= 1'b0;
      out_stop_err <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      overrun <= done & out_valid & ~out_ready;
      if (done && (!out_valid || out_ready)) begin
        out_valid    <= 1'b1;
        out_data     <= shreg;
        out_par_err  <= fin_par_err;
        out_stop_err <= fin_stop_err;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  uart_sat_counter #(
    .CNT_WIDTH(CNT_WIDTH)
  ) u_par_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .inc  (done & fin_par_err),
    .clr  (clr_cnt),
    .cnt  (par_err_cnt)
  );

  uart_sat_counter #(
    .CNT_WIDTH(CNT_WIDTH)
  ) u_stop_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .inc  (done & fin_stop_err),
    .clr  (clr_cnt),
    .cnt  (stop_err_cnt)
  );

endmodule

// File: tb/tb_uart_rx_frame_check.sv
// Scoreboard bench: unit A (8 data, 1 stop, 2-bit counters)
// and unit B (7 data, 2 stop, no parity).
module tb_uart_rx_frame_check;

  typedef struct {
    logic [8:0] d;
    bit         pe;
    bit         se;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];

  int n_cmp = 0;
  int n_err = 0;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic       a_par_en = 1'b1;
  logic [1:0] a_par_type = 2'b00;
  logic       a_start = 0, a_bit = 0, a_val = 0;
  logic       a_ready = 1'b1, a_clr = 1'b0;
  logic [7:0] a_data;
  logic       a_pe, a_se, a_valid, a_ovr, a_busy;
  logic [1:0] a_pcnt, a_scnt;

  logic        b_par_en = 1'b0;
  logic [1:0]  b_par_type = 2'b00;
  logic        b_start = 0, b_bit = 0, b_val = 0;
  logic        b_ready = 1'b1, b_clr = 1'b0;
  logic [6:0]  b_data;
  logic        b_pe, b_se, b_valid, b_ovr, b_busy;
  logic [15:0] b_pcnt, b_scnt;

  always #5 clk = ~clk;

  uart_rx_frame_check #(
    .DATA_WIDTH(8), .STOP_BITS(1), .CNT_WIDTH(2)
  ) dut_a (
    .clk(clk), .rst_n(rst_n),
    .cfg_par_en(a_par_en), .cfg_par_type(a_par_type),
    .start_stb(a_start), .bit_stb(a_bit), .bit_val(a_val),
    .out_data(a_data), .out_par_err(a_pe),
    .out_stop_err(a_se), .out_valid(a_valid),
    .out_ready(a_ready), .overrun(a_ovr), .busy(a_busy),
    .clr_cnt(a_clr), .par_err_cnt(a_pcnt),
    .stop_err_cnt(a_scnt)
  );

  uart_rx_frame_check #(
    .DATA_WIDTH(7), .STOP_BITS(2), .CNT_WIDTH(16)
  ) dut_b (
    .clk(clk), .rst_n(rst_n),
    .cfg_par_en(b_par_en), .cfg_par_type(b_par_type),
    .start_stb(b_start), .bit_stb(b_bit), .bit_val(b_val),
    .out_data(b_data), .out_par_err(b_pe),
    .out_stop_err(b_se), .out_valid(b_valid),
    .out_ready(b_ready), .overrun(b_ovr), .busy(b_busy),
    .clr_cnt(b_clr), .par_err_cnt(b_pcnt),
    .stop_err_cnt(b_scnt)
  );

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (a_valid && a_ready) begin
      if (qa.size() == 0) begin
        chk("a_unexpected_frame", {24'h0, a_data}, 32'hFFFF);
      end else begin
        e = qa.pop_front();
        chk("a_data", {24'h0, a_data}, {23'h0, e.d});
        chk("a_par_err", {31'h0, a_pe}, {31'h0, e.pe});
        chk("a_stop_err", {31'h0, a_se}, {31'h0, e.se});
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (b_valid && b_ready) begin
      if (qb.size() == 0) begin
        chk("b_unexpected_frame", {25'h0, b_data}, 32'hFFFF);
      end else begin
        e = qb.pop_front();
        chk("b_data", {25'h0, b_data}, {25'h0, e.d[6:0]});
        chk("b_par_err", {31'h0, b_pe}, {31'h0, e.pe});
        chk("b_stop_err", {31'h0, b_se}, {31'h0, e.se});
      end
    end
  end

  task automatic idle();
    @(posedge clk);
    #1;
  endtask

  task automatic stb(input bit u, input bit s, input bit b,
                     input bit v, input bit c);
    if (!u) begin
      a_start = s; a_bit = b; a_val = v; a_clr = c;
    end else begin
      b_start = s; b_bit = b; b_val = v; b_clr = c;
    end
    idle();
    a_start = 0; a_bit = 0; a_val = 0; a_clr = 0;
    b_start = 0; b_bit = 0; b_val = 0; b_clr = 0;
  endtask

  task automatic push(input bit u, input logic [8:0] d,
                      input bit pe, input bit se);
    exp_t e;
    e.d = d; e.pe = pe; e.se = se;
    if (!u) qa.push_back(e);
    else    qb.push_back(e);
  endtask

  // Returns right after the edge sampling the last stop bit.
  task automatic send(input bit u, input logic [8:0] d,
                      input int nd, input bit hp,
                      input bit pb, input bit s0,
                      input bit s1, input int ns,
                      input bit clr_last = 0,
                      input bit both = 0,
                      input int inj = -1,
                      input bit rdy_last = 0);
    stb(u, 1, both, 1'b1, 0);
    idle();
    for (int i = 0; i < nd; i++) begin
      if (i == inj) begin
        stb(u, 1, 0, 0, 0);
        idle();
      end
      stb(u, 0, 1, d[i], 0);
      idle();
    end
    if (hp) begin
      stb(u, 0, 1, pb, 0);
      idle();
    end
    for (int i = 0; i < ns; i++) begin
      if (i == ns - 1 && rdy_last) begin
        if (!u) a_ready = 1'b1;
        else    b_ready = 1'b1;
      end
      stb(u, 0, 1, (i == 0) ? s0 : s1,
          clr_last && (i == ns - 1));
      if (i < ns - 1) idle();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    repeat (3) idle();
    chk("rst_valid", {31'h0, a_valid}, 0);
    chk("rst_data", {24'h0, a_data}, 0);
    chk("rst_busy", {31'h0, a_busy}, 0);
    chk("rst_flags", {29'h0, a_pe, a_se, a_ovr}, 0);
    chk("rst_cnts", {28'h0, a_pcnt, a_scnt}, 0);
    chk("rst_b", {30'h0, b_valid, b_busy}, 0);
    rst_n = 1'b1;
    idle();

    // even, 0xA5 has four ones -> parity bit 0
    a_par_type = 2'b00;
    push(0, 9'hA5, 0, 0);
    send(0, 9'hA5, 8, 1, 0, 1, 1, 1);
    chk("t1_valid_lat", {31'h0, a_valid}, 1);
    chk("t1_busy", {31'h0, a_busy}, 0);
    idle(); idle();

    a_par_type = 2'b01;
    push(0, 9'h01, 1, 0);
    send(0, 9'h01, 8, 1, 1, 1, 1, 1);
    chk("t2_pcnt1", {30'h0, a_pcnt}, 1);
    idle();

    a_par_type = 2'b10;
    push(0, 9'h3C, 1, 0);
    send(0, 9'h3C, 8, 1, 0, 1, 1, 1);
    chk("t2_mark_bad", {30'h0, a_pcnt}, 2);
    idle();
    push(0, 9'h00, 0, 0);
    send(0, 9'h00, 8, 1, 1, 1, 1, 1);
    chk("t2_mark_ok", {30'h0, a_pcnt}, 2);
    idle();

    a_par_type = 2'b11;
    push(0, 9'hFF, 1, 0);
    send(0, 9'hFF, 8, 1, 1, 1, 1, 1);
    chk("t2_space_bad", {30'h0, a_pcnt}, 3);
    idle();

    a_par_type = 2'b01;
    push(0, 9'h01, 1, 0);
    send(0, 9'h01, 8, 1, 1, 1, 1, 1);
    chk("t5_saturate", {30'h0, a_pcnt}, 3);
    idle();

    // even, 0x80 -> parity bit 1 correct; bad stop
    a_par_type = 2'b00;
    push(0, 9'h80, 0, 1);
    send(0, 9'h80, 8, 1, 1, 0, 1, 1);
    chk("a_scnt1", {30'h0, a_scnt}, 1);
    idle();

    a_par_type = 2'b01;
    push(0, 9'h01, 1, 0);
    send(0, 9'h01, 8, 1, 1, 1, 1, 1, 1);
    chk("t5_clr_pcnt", {30'h0, a_pcnt}, 0);
    chk("t5_clr_scnt", {30'h0, a_scnt}, 0);
    idle();

    a_par_type = 2'b10;
    push(0, 9'h0F, 1, 0);
    send(0, 9'h0F, 8, 1, 0, 1, 1, 1);
    chk("after_clr_pcnt", {30'h0, a_pcnt}, 1);
    idle(); idle();

    // overrun: 0x11 held, 0x22 with bad parity dropped
    a_par_type = 2'b00;
    a_ready = 1'b0;
    push(0, 9'h011, 0, 0);
    send(0, 9'h11, 8, 1, 0, 1, 1, 1);
    idle();
    send(0, 9'h22, 8, 1, 1, 1, 1, 1);
    chk("t4_ovr_pulse", {31'h0, a_ovr}, 1);
    chk("t4_held_data", {24'h0, a_data}, 32'h11);
    chk("t4_drop_cnt", {30'h0, a_pcnt}, 2);
    idle();
    chk("t4_ovr_once", {31'h0, a_ovr}, 0);
    a_ready = 1'b1;
    idle();
    a_ready = 1'b0;
    idle();

    push(0, 9'h33, 0, 0);
    send(0, 9'h33, 8, 1, 0, 1, 1, 1);
    idle();
    push(0, 9'h44, 0, 0);
    send(0, 9'h44, 8, 1, 0, 1, 1, 1, 0, 0, -1, 1);
    chk("t4_no_ovr", {31'h0, a_ovr}, 0);
    chk("t4_new_data", {24'h0, a_data}, 32'h44);
    idle(); idle();

    // unit B: 7 data bits, no parity, two stops
    push(1, 9'h55, 0, 0);
    send(1, 9'h55, 7, 0, 0, 1, 1, 2);
    chk("b_valid_lat", {31'h0, b_valid}, 1);
    idle();
    push(1, 9'h2A, 0, 1);
    send(1, 9'h2A, 7, 0, 0, 1, 0, 2);
    chk("b_scnt1", b_scnt, 1);
    chk("b_pcnt0", b_pcnt, 0);
    idle(); idle();

    // reset after 4 data bits of a frame
    stb(0, 1, 0, 1, 0);
    for (int i = 0; i < 4; i++) stb(0, 0, 1, 1'b1, 0);
    chk("t6_busy_mid", {31'h0, a_busy}, 1);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_busy", {31'h0, a_busy}, 0);
    chk("t6_rst_valid", {31'h0, a_valid}, 0);
    chk("t6_rst_pcnt", {30'h0, a_pcnt}, 0);
    chk("t6_rst_b_scnt", b_scnt, 0);
    idle(); idle();
    rst_n = 1'b1;
    idle();

    // start+bit together, stray start mid-DATA
    a_par_type = 2'b00;
    push(0, 9'h5A, 0, 0);
    send(0, 9'h5A, 8, 1, 0, 1, 1, 1, 0, 1, 3);
    chk("t6_valid", {31'h0, a_valid}, 1);

    for (int i = 0; i < 20; i++) begin
      if (qa.size() == 0 && qb.size() == 0) break;
      idle();
    end
    chk("qa_drained", qa.size(), 0);
    chk("qb_drained", qb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_cmp, n_err);
    $finish;
  end

endmodule
